// File: rtl/k10_prefetch_unit.sv
// Instruction prefetcher: word fetcher with in-order response FIFO and a
// halfword realigner that presents 16-bit and 32-bit instructions.
module k10_prefetch_unit #(
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pc_set,
    input  logic [31:0] i_pc_target,
    output logic        o_ibus_req,
    output logic [31:0] o_ibus_addr,
    input  logic        i_ibus_gnt,
    input  logic        i_ibus_rvalid,
    input  logic [31:0] i_ibus_rdata,
    input  logic        i_ibus_err,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_is_compressed,
    output logic        o_ibus_err,
    output logic        o_busy
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   fetch_addr;
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic          mem_err  [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [31:0]   held_instr;
    logic          held_comp;
    logic          held_err;

    logic [31:0] h0;
    logic [15:0] h1_lo;
    logic        e0;
    logic        e1;
    logic [15:0] half;
    logic        comp;
    logic        needs_two;
    logic        valid;
    logic [31:0] instr;
    logic        err;
    logic [CW-1:0] occ_eff;
    logic [CW:0]   inflight_sum;
    logic        rv_ok;
    logic        gnt;
    logic        push;
    logic        pop;
    logic        fire;
    logic        target_unused;

    assign target_unused = i_pc_target[0];

    assign h0    = mem_data[rd_ptr];
    assign h1_lo = mem_data[rd_ptr + PW'(1)][15:0];
    assign e0    = mem_err[rd_ptr];
    assign e1    = mem_err[rd_ptr + PW'(1)];

    assign half      = pc[1] ? h0[31:16] : h0[15:0];
    assign comp      = (half[1:0] != 2'b11);
    assign needs_two = !comp && pc[1];
    assign instr     = comp ? {16'h0000, half} : (pc[1] ? {h1_lo, h0[31:16]} : h0);
    assign err       = e0 | (needs_two & e1);
    assign valid     = !i_pc_set && (needs_two ? (count >= CW'(2)) : (count != '0));

    // A redirect empties the FIFO at the edge, so its words no longer block requests.
    assign occ_eff      = i_pc_set ? '0 : count;
    assign inflight_sum = {1'b0, outstanding} + {1'b0, occ_eff};
    assign o_ibus_req   = (outstanding < MAX_OUT) && (inflight_sum < DEPTH_W);
    assign o_ibus_addr  = i_pc_set ? {i_pc_target[31:2], 2'b00} : fetch_addr;

    assign rv_ok = i_ibus_rvalid && (outstanding != '0);
    assign gnt   = o_ibus_req && i_ibus_gnt;
    assign push  = rv_ok && (discard == '0) && !i_pc_set;
    assign fire  = valid && i_ready;
    assign pop   = fire && (pc[1] || !comp);

    assign o_valid         = valid;
    assign o_pc            = pc;
    assign o_instr         = valid ? instr : held_instr;
    assign o_is_compressed = valid ? comp  : held_comp;
    assign o_ibus_err      = valid ? err   : held_err;
    assign o_busy          = !valid && !i_pc_set;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data[wr_ptr] <= i_ibus_rdata;
            mem_err[wr_ptr]  <= i_ibus_err;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc          <= BOOT_ADDR;
            fetch_addr  <= {BOOT_ADDR[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            held_instr  <= '0;
            held_comp   <= 1'b0;
            held_err    <= 1'b0;
        end else begin
            outstanding <= outstanding - CW'(rv_ok) + CW'(gnt);
            fetch_addr  <= o_ibus_addr + (gnt ? 32'd4 : 32'd0);
            if (valid) begin
                held_instr <= instr;
                held_comp  <= comp;
                held_err   <= err;
            end
            if (i_pc_set) begin
                // Every request issued before the redirect is stale, except one answered now.
                pc      <= {i_pc_target[31:1], 1'b0};
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                discard <= outstanding - CW'(rv_ok);
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (rv_ok && (discard != '0)) discard <= discard - CW'(1);
                if (fire) pc <= pc + (comp ? 32'd2 : 32'd4);
            end
        end
    end
endmodule

// File: tb/tb_k10_prefetch_unit.sv
// Self-checking bench for k10_prefetch_unit: a memory image, an in-order bus
// responder and an instruction-stream reference model derived from the image.
module tb_k10_prefetch_unit;
    localparam logic [31:0] BOOT  = 32'h0000_0000;
    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_set = 1'b0;
    logic [31:0] pc_target = '0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt = 1'b0;
    logic        ibus_rvalid = 1'b0;
    logic [31:0] ibus_rdata = '0;
    logic        ibus_err_in = 1'b0;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_compressed;
    logic        instr_err;
    logic        busy;

    always #5 clk = ~clk;

    k10_prefetch_unit #(
        .BOOT_ADDR      (BOOT),
        .FIFO_DEPTH     (DEPTH),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_pc_set       (pc_set),
        .i_pc_target    (pc_target),
        .o_ibus_req     (ibus_req),
        .o_ibus_addr    (ibus_addr),
        .i_ibus_gnt     (ibus_gnt),
        .i_ibus_rvalid  (ibus_rvalid),
        .i_ibus_rdata   (ibus_rdata),
        .i_ibus_err     (ibus_err_in),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_pc           (pc),
        .o_instr        (instr),
        .o_is_compressed(is_compressed),
        .o_ibus_err     (instr_err),
        .o_busy         (busy)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } req_t;

    req_t        q[$];
    logic [31:0] img [256];
    bit          img_err [256];
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_avail;
    logic [31:0] hold_instr;
    bit          hold_comp;
    bit          hold_err;
    int          rv_block = 0;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = img[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pc_set = 1'b0;
        ready = 1'b0;
        ibus_gnt = 1'b0;
        ibus_rvalid = 1'b0;
        #4;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_pc", pc, BOOT);
        chk("rst_addr", ibus_addr, {BOOT[31:2], 2'b00});
        chk("rst_instr", instr, 32'd0);
        chk("rst_comp", 32'(is_compressed), 32'd0);
        chk("rst_err", 32'(instr_err), 32'd0);
        q.delete();
        m_pc = BOOT;
        m_fetch = {BOOT[31:2], 2'b00};
        m_avail = m_fetch;
        hold_instr = '0;
        hold_comp = 1'b0;
        hold_err = 1'b0;
        rv_block = 2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Called 1 time unit after a rising edge; checks at the falling edge.
    task automatic cycle(input bit set, input logic [31:0] tgt, input int rdy_pct,
                         input int gnt_pct, input int rv_pct, input bit spurious);
        logic [15:0] first;
        logic [31:0] p2;
        logic [31:0] e_instr;
        bit          e_comp;
        bit          e_err;
        bit          e_valid;
        bit          e_req;
        bit          rv_now;
        int          len;
        int          occ;
        req_t        r;

        pc_set = set;
        pc_target = tgt;
        ready = ($urandom_range(99) < rdy_pct);
        ibus_gnt = ($urandom_range(99) < gnt_pct);
        rv_now = 1'b0;
        if (rv_block == 0) begin
            if (q.size() > 0) rv_now = ($urandom_range(99) < rv_pct);
            else              rv_now = spurious;
        end
        ibus_rvalid = rv_now;
        if (rv_now && q.size() > 0) begin
            ibus_rdata  = img[q[0].addr[9:2]];
            ibus_err_in = img_err[q[0].addr[9:2]];
        end else begin
            ibus_rdata  = $urandom;
            ibus_err_in = 1'($urandom_range(1));
        end
        #4;

        first   = half_at(m_pc);
        p2      = m_pc + 32'd2;
        e_comp  = (first[1:0] != 2'b11);
        len     = e_comp ? 2 : 4;
        e_instr = e_comp ? {16'h0000, first} : {half_at(p2), first};
        e_err   = img_err[m_pc[9:2]] | (!e_comp & img_err[p2[9:2]]);
        e_valid = !set && ((m_pc + 32'(len)) <= m_avail);
        occ     = int'((m_avail - {m_pc[31:2], 2'b00}) >> 2);
        e_req   = (q.size() < MAXO) && ((q.size() + (set ? 0 : occ)) < DEPTH);

        chk("req", 32'(ibus_req), 32'(e_req));
        chk("addr", ibus_addr, set ? {tgt[31:2], 2'b00} : m_fetch);
        chk("valid", 32'(valid), 32'(e_valid));
        chk("busy", 32'(busy), 32'(!e_valid && !set));
        chk("pc", pc, m_pc);
        if (e_valid) begin
            chk("instr", instr, e_instr);
            chk("compressed", 32'(is_compressed), 32'(e_comp));
            chk("instr_err", 32'(instr_err), 32'(e_err));
        end else begin
            chk("hold_instr", instr, hold_instr);
            chk("hold_comp", 32'(is_compressed), 32'(hold_comp));
            chk("hold_err", 32'(instr_err), 32'(hold_err));
        end

        if (set) begin
            foreach (q[i]) begin
                r = q[i];
                r.stale = 1'b1;
                q[i] = r;
            end
            if (rv_now && q.size() > 0) r = q.pop_front();
            m_pc    = {tgt[31:1], 1'b0};
            m_fetch = {tgt[31:2], 2'b00};
            m_avail = m_fetch;
        end else begin
            if (rv_now && q.size() > 0) begin
                r = q.pop_front();
                if (!r.stale) m_avail = m_avail + 32'd4;
            end
            if (e_valid) begin
                hold_instr = e_instr;
                hold_comp  = e_comp;
                hold_err   = e_err;
                if (ready) m_pc = m_pc + 32'(len);
            end
        end
        if (e_req && ibus_gnt) begin
            r.addr  = m_fetch;
            r.stale = 1'b0;
            q.push_back(r);
            m_fetch = m_fetch + 32'd4;
        end
        if (rv_block > 0) rv_block--;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tgt;
        bit          redir;
        foreach (img[i]) begin
            img[i] = 32'h0000_0013;
            img_err[i] = 1'b0;
        end
        #1;
        do_reset();

        // Idle start; the third cycle carries an rvalid with nothing outstanding.
        repeat (3) cycle(1'b0, '0, 100, 0, 0, 1'b1);

        // Zero-wait streaming of 32-bit instructions.
        repeat (20) cycle(1'b0, '0, 100, 100, 100, 1'b0);

        // Compressed mix, boundary-spanning 32-bit instruction, error on word 0x8.
        img[0] = 32'h0001_4501;
        img[1] = 32'h0093_0001;
        img[2] = 32'h4501_0013;
        img[3] = 32'h0000_0013;
        img_err[2] = 1'b1;
        cycle(1'b1, 32'h0000_0000, 100, 100, 100, 1'b0);
        repeat (16) cycle(1'b0, '0, 100, 100, 100, 1'b0);

        // Backpressure, then release.
        repeat (10) cycle(1'b0, '0, 0, 100, 100, 1'b0);
        repeat (10) cycle(1'b0, '0, 100, 100, 100, 1'b0);

        // Redirect to 0x102 with requests in flight and no responses.
        img[64] = 32'h4501_0013;
        img[65] = 32'h0000_0013;
        repeat (4) cycle(1'b0, '0, 100, 100, 0, 1'b0);
        cycle(1'b1, 32'h0000_0103, 100, 0, 0, 1'b0);
        repeat (12) cycle(1'b0, '0, 100, 100, 100, 1'b0);

        // Randomized image and traffic with occasional redirects.
        foreach (img[i]) begin
            img[i] = $urandom;
            img_err[i] = ($urandom_range(15) == 0);
        end
        cycle(1'b1, 32'h0000_0010, 100, 100, 100, 1'b0);
        repeat (400) begin
            redir = ($urandom_range(19) == 0) || (m_pc > 32'h0000_0380);
            tgt   = $urandom_range(32'h300);
            cycle(redir, tgt, 70, 70, 70, 1'b0);
        end

        // Reset with two requests in flight, then resume random traffic.
        repeat (3) cycle(1'b0, '0, 100, 100, 0, 1'b0);
        do_reset();
        repeat (120) begin
            redir = ($urandom_range(19) == 0) || (m_pc > 32'h0000_0380);
            tgt   = $urandom_range(32'h300);
            cycle(redir, tgt, 70, 70, 70, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
